// File: rtl/qvga_fb_arbiter.sv
// Single-port QVGA frame-buffer arbiter: display reads have strict priority over FIFO-queued camera writes.
// Define QVGA_ARB_STALL_CNT_EN to build the saturating write-stall counter; otherwise stall_cnt is tied to 0.
module qvga_fb_arbiter #(
    parameter int ADDR_W     = 17,
    parameter int DATA_W     = 12,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          rd_req,
    input  logic [ADDR_W-1:0]             rd_addr,
    output logic                          rd_valid,
    output logic [DATA_W-1:0]             rd_data,
    input  logic                          wr_req,
    input  logic [ADDR_W-1:0]             wr_addr,
    input  logic [DATA_W-1:0]             wr_data,
    output logic                          wr_ready,
    output logic                          mem_en,
    output logic                          mem_we,
    output logic [ADDR_W-1:0]             mem_addr,
    output logic [DATA_W-1:0]             mem_wdata,
    input  logic [DATA_W-1:0]             mem_rdata,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic [15:0]                   stall_cnt
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam longint unsigned FB_PIXELS = 76800;

    typedef enum logic [1:0] {IDLE = 2'd0, RD = 2'd1, WR = 2'd2} gnt_t;

    function automatic logic in_frame(input logic [ADDR_W-1:0] a);
        return 64'(a) < FB_PIXELS;
    endfunction

    gnt_t              gnt, gnt_nxt;
    logic [ADDR_W-1:0] fifo_addr [FIFO_DEPTH];
    logic [DATA_W-1:0] fifo_data [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr, rd_ptr;
    logic [ADDR_W-1:0] head_addr;
    logic [DATA_W-1:0] head_data;
    logic              push, pop;
    logic              en_nxt, we_nxt;
    logic [ADDR_W-1:0] addr_nxt;
    logic [DATA_W-1:0] wdata_nxt;
    logic              vld_p1, rd_hit_p1;

    assign wr_ready  = (fifo_level != LVL_W'(FIFO_DEPTH));
    assign push      = wr_req && wr_ready;
    assign pop       = (gnt_nxt == WR);
    assign head_addr = fifo_addr[rd_ptr];
    assign head_data = fifo_data[rd_ptr];

    // Write FIFO control; pointers wrap naturally because the depth is a power of two
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   fifo_level <= fifo_level + LVL_W'(1);
                2'b01:   fifo_level <= fifo_level - LVL_W'(1);
                default: fifo_level <= fifo_level;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_addr[wr_ptr] <= wr_addr;
            fifo_data[wr_ptr] <= wr_data;
        end
    end

    always_comb begin
        gnt_nxt = IDLE;
        if (rd_req)
            gnt_nxt = RD;
        else if (fifo_level != '0)
            gnt_nxt = WR;
    end

    // Off-frame accesses keep their grant slot but never reach the memory
    always_comb begin
        en_nxt    = 1'b0;
        we_nxt    = 1'b0;
        addr_nxt  = '0;
        wdata_nxt = '0;
        case (gnt_nxt)
            RD: begin
                if (in_frame(rd_addr)) begin
                    en_nxt   = 1'b1;
                    addr_nxt = rd_addr;
                end
            end
            WR: begin
                if (in_frame(head_addr)) begin
                    en_nxt    = 1'b1;
                    we_nxt    = 1'b1;
                    addr_nxt  = head_addr;
                    wdata_nxt = head_data;
                end
            end
            default: ;
        endcase
    end

    // Command stage (p0) and read-return stage (p1)
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            gnt       <= IDLE;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            vld_p1    <= 1'b0;
            rd_hit_p1 <= 1'b0;
        end else begin
            gnt       <= gnt_nxt;
            mem_en    <= en_nxt;
            mem_we    <= we_nxt;
            mem_addr  <= addr_nxt;
            mem_wdata <= wdata_nxt;
            vld_p1    <= (gnt == RD);
            rd_hit_p1 <= (gnt == RD) && mem_en;
        end
    end

    assign rd_valid = vld_p1;
    assign rd_data  = (vld_p1 && rd_hit_p1) ? mem_rdata : '0;

`ifdef QVGA_ARB_STALL_CNT_EN
    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            stall_cnt <= '0;
        else if (wr_req && !wr_ready)
            stall_cnt <= sat_inc16(stall_cnt);
    end
`else
    assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_qvga_fb_arbiter.sv
// Directed self-checking bench for qvga_fb_arbiter with a registered frame-buffer model.
module tb_qvga_fb_arbiter;
    localparam int ADDR_W = 17;
    localparam int DATA_W = 12;
    localparam int FIFO_DEPTH = 8;
`ifdef QVGA_ARB_STALL_CNT_EN
    localparam bit STALL_EN = 1'b1;
`else
    localparam bit STALL_EN = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              reset;
    logic              rd_req, wr_req;
    logic [ADDR_W-1:0] rd_addr, wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              rd_valid, wr_ready, mem_en, mem_we;
    logic [DATA_W-1:0] rd_data, mem_wdata;
    logic [DATA_W-1:0] mem_rdata = '0;
    logic [ADDR_W-1:0] mem_addr;
    logic [3:0]        fifo_level;
    logic [15:0]       stall_cnt;

    int n_chk = 0;
    int n_bad = 0;
    int en_cnt = 0;
    logic [DATA_W-1:0] fbm [1024];
    logic [ADDR_W-1:0] log_addr [$];
    logic [DATA_W-1:0] log_data [$];

    always #5 clk = ~clk;

    qvga_fb_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .FIFO_DEPTH(FIFO_DEPTH)) dut (
        .clk(clk), .reset(reset),
        .rd_req(rd_req), .rd_addr(rd_addr), .rd_valid(rd_valid), .rd_data(rd_data),
        .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ready(wr_ready),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .fifo_level(fifo_level), .stall_cnt(stall_cnt)
    );

    always @(posedge clk) begin
        if (mem_en) begin
            en_cnt <= en_cnt + 1;
            if (mem_we) begin
                fbm[mem_addr[9:0]] <= mem_wdata;
                log_addr.push_back(mem_addr);
                log_data.push_back(mem_wdata);
            end else begin
                mem_rdata <= fbm[mem_addr[9:0]];
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        for (int k = 0; k < n; k++) @(negedge clk);
    endtask

    int acc, e0, l0;

    initial begin
        for (int i = 0; i < 1024; i++) fbm[i] = 12'(i * 3 + 7);
        fbm[100] = 12'hABC;
        reset = 1'b1; rd_req = 1'b0; wr_req = 1'b0;
        rd_addr = '0; wr_addr = '0; wr_data = '0;
        step(2);
        chk("rst_wr_ready", wr_ready, 1);
        chk("rst_rd_data", rd_data, 0);
        chk("rst_rd_valid", rd_valid, 0);
        chk("rst_mem_en", mem_en, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_level", fifo_level, 0);
        chk("rst_stall", stall_cnt, 0);
        reset = 1'b0;
        step(2);

        // single read
        rd_req = 1'b1; rd_addr = 100;
        step(1);
        rd_req = 1'b0;
        chk("rd_mem_en", mem_en, 1);
        chk("rd_mem_we", mem_we, 0);
        chk("rd_mem_addr", mem_addr, 100);
        chk("rd_valid_n1", rd_valid, 0);
        step(1);
        chk("rd_valid_n2", rd_valid, 1);
        chk("rd_data_n2", rd_data, 12'hABC);
        step(1);
        chk("rd_valid_n3", rd_valid, 0);
        chk("rd_data_n3", rd_data, 0);

        // three writes, no reads
        log_addr.delete(); log_data.delete();
        for (int i = 0; i < 3; i++) begin
            wr_req = 1'b1; wr_addr = ADDR_W'(i); wr_data = DATA_W'(i + 1);
            step(1);
            if (i == 0) chk("w3_level1", fifo_level, 1);
        end
        wr_req = 1'b0;
        step(4);
        chk("w3_count", log_addr.size(), 3);
        for (int i = 0; i < 3 && i < log_addr.size(); i++) begin
            chk("w3_addr", log_addr[i], i);
            chk("w3_data", log_data[i], i + 1);
        end
        chk("w3_level0", fifo_level, 0);

        // reads hold off writes; FIFO fills to depth
        log_addr.delete(); log_data.delete();
        acc = 0;
        for (int i = 0; i < 20; i++) begin
            rd_req = 1'b1; rd_addr = ADDR_W'(200 + i);
            if (i < 10) begin
                wr_req = 1'b1; wr_addr = ADDR_W'(10 + i); wr_data = DATA_W'(12'h100 + i);
                if (wr_ready) acc++;
                if (i == 8) begin
                    chk("full_wr_ready", wr_ready, 0);
                    chk("full_level", fifo_level, 8);
                end
            end else begin
                wr_req = 1'b0;
            end
            step(1);
        end
        rd_req = 1'b0; wr_req = 1'b0;
        chk("rdprio_accepted", acc, 8);
        chk("rdprio_no_we", log_addr.size(), 0);
        chk("rdprio_level", fifo_level, 8);
        chk("rdprio_stall", stall_cnt, STALL_EN ? 2 : 0);
        step(1);
        chk("drain_first_we", mem_we, 1);
        chk("drain_first_addr", mem_addr, 10);
        step(10);
        chk("drain_count", log_addr.size(), 8);
        for (int i = 0; i < 8 && i < log_addr.size(); i++) begin
            chk("drain_addr", log_addr[i], 10 + i);
            chk("drain_data", log_data[i], 12'h100 + i);
        end
        chk("drain_level", fifo_level, 0);

        // stall counter
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        chk("stall_after_rst", stall_cnt, 0);
        for (int i = 0; i < 13; i++) begin
            rd_req = 1'b1; rd_addr = ADDR_W'(300 + i);
            wr_req = 1'b1; wr_addr = ADDR_W'(40 + i); wr_data = DATA_W'(i);
            step(1);
        end
        wr_req = 1'b0;
        chk("stall_cnt5", stall_cnt, STALL_EN ? 5 : 0);
        step(1);
        chk("stall_hold", stall_cnt, STALL_EN ? 5 : 0);
        rd_req = 1'b0;
        step(10);
        chk("stall_drained", fifo_level, 0);

        // off-frame write and read
        e0 = en_cnt;
        wr_req = 1'b1; wr_addr = 76800; wr_data = 12'h005;
        step(1);
        wr_req = 1'b0; rd_req = 1'b1; rd_addr = 80000;
        step(1);
        rd_req = 1'b0;
        chk("off_rd_en", mem_en, 0);
        chk("off_level1", fifo_level, 1);
        step(1);
        chk("off_wr_en", mem_en, 0);
        chk("off_rd_valid", rd_valid, 1);
        chk("off_rd_data", rd_data, 0);
        step(3);
        chk("off_no_en", en_cnt - e0, 0);
        chk("off_level0", fifo_level, 0);

        // reset with queued writes and reads in flight
        for (int i = 0; i < 4; i++) begin
            rd_req = 1'b1; rd_addr = 400;
            wr_req = 1'b1; wr_addr = ADDR_W'(30 + i); wr_data = DATA_W'(i);
            step(1);
        end
        wr_req = 1'b0;
        chk("pre_rst_level", fifo_level, 4);
        reset = 1'b1;
        #1;
        chk("mid_rst_level", fifo_level, 0);
        chk("mid_rst_rd_valid", rd_valid, 0);
        chk("mid_rst_mem_en", mem_en, 0);
        chk("mid_rst_rd_data", rd_data, 0);
        rd_req = 1'b0;
        step(1);
        reset = 1'b0;
        e0 = en_cnt; l0 = log_addr.size();
        step(12);
        chk("post_rst_no_en", en_cnt - e0, 0);
        chk("post_rst_no_wr", log_addr.size() - l0, 0);
        chk("post_rst_rd_valid", rd_valid, 0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end
endmodule

// File: doc/qvga_fb_arbiter.md
QVGA_FB_ARBITER -- requirements
Module: qvga_fb_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 17, frame-buffer address width.
REQ-002 SHALL have parameter DATA_W, default 12, pixel width (RGB444).
REQ-003 SHALL have parameter FIFO_DEPTH, default 8, write-FIFO entries (power of two, at least 2).
REQ-004 SHALL have port clk, input, 1, the single clock.
REQ-005 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-006 SHALL have ports rd_req input 1, rd_addr input ADDR_W: display read request and address.
REQ-007 SHALL have ports rd_valid output 1, rd_data output DATA_W: read return.
REQ-008 SHALL have ports wr_req input 1, wr_addr input ADDR_W, wr_data input DATA_W: camera write request.
REQ-009 SHALL have port wr_ready, output, 1, write accepted this cycle when wr_req is high.
REQ-010 SHALL have ports mem_en output 1, mem_we output 1, mem_addr output ADDR_W, mem_wdata output DATA_W: single-port frame-buffer command.
REQ-011 SHALL have port mem_rdata, input, DATA_W, read data, valid 1 cycle after mem_en with mem_we low.
REQ-012 SHALL have ports fifo_level output $clog2(FIFO_DEPTH)+1 and stall_cnt output 16.

Function
REQ-013 SHALL push {wr_addr, wr_data} into the FIFO on a cycle where wr_req and wr_ready are both high.
REQ-014 SHALL drive wr_ready = (fifo_level != FIFO_DEPTH); a push while full is impossible even on a pop cycle.
REQ-015 SHALL decide one grant per cycle: READ if rd_req; else WRITE if FIFO non-empty; else IDLE (strict read priority).
REQ-016 SHALL register the grant in state gnt {IDLE, RD, WR}; mem_* outputs are registered and reflect the grant one cycle after the decision.
REQ-017 SHALL, in RD: mem_en=1, mem_we=0, mem_addr=captured rd_addr, mem_wdata=0.
REQ-018 SHALL, in WR: mem_en=1, mem_we=1, mem_addr/mem_wdata=FIFO head; pop occurs on the decision cycle.
REQ-019 SHALL, in IDLE: mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0.
REQ-020 SHALL assert rd_valid exactly 2 cycles after the rd_req cycle; rd_data=mem_rdata when rd_valid, else 0.
REQ-021 SHALL treat a read with rd_addr >= 76800 as RD with mem_en=0; rd_valid still fires at +2 with rd_data=0.
REQ-022 SHALL pop and discard FIFO entries with address >= 76800 as WR with mem_en=0, mem_we=0.
REQ-023 SHALL update fifo_level by +1 on push-only, -1 on pop-only, and unchanged on simultaneous push and pop.
REQ-024 SHALL wrap FIFO pointers modulo FIFO_DEPTH and preserve write order.
REQ-025 SHALL accept back-to-back reads every cycle; the FIFO drains only on cycles with rd_req low.

Reset
REQ-026 SHALL, on reset, asynchronously clear FIFO pointers, fifo_level, gnt (to IDLE), rd_valid pipeline, stall_cnt and all mem_* outputs to 0.
REQ-027 SHALL drive wr_ready=1 and rd_data=0 while reset is high.
REQ-028 SHALL discard in-flight reads and queued writes on reset mid-operation; no mem_en is issued for them afterwards.

Configuration
REQ-029 SHALL, with macro QVGA_ARB_STALL_CNT_EN defined, increment stall_cnt each cycle wr_req=1 and wr_ready=0, saturating at 16'hFFFF.
REQ-030 SHALL, without QVGA_ARB_STALL_CNT_EN, tie stall_cnt to 0 and include no counter logic.

Verification
REQ-031 SHALL cover: single rd_req with rd_addr=100 at cycle N, mem_rdata=12'hABC -> mem_en=1/mem_we=0/mem_addr=100 at N+1; rd_valid=1, rd_data=12'hABC at N+2.
REQ-032 SHALL cover: 3 writes (addr 0,1,2; data 1,2,3) with rd_req low -> three mem_we pulses in order 0,1,2; fifo_level returns to 0.
REQ-033 SHALL cover: rd_req held high 20 cycles while 10 writes are offered -> 8 accepted, wr_ready=0 after the 8th, no mem_we during reads; 8 writes drain after rd_req drops.
REQ-034 SHALL cover: with the macro, wr_req held 5 cycles with the FIFO full -> stall_cnt=5; without the macro, stall_cnt=0.
REQ-035 SHALL cover: write to addr 76800 and read from addr 80000 -> no mem_en for either; rd_valid at +2 with rd_data=0; fifo_level returns to 0.
REQ-036 SHALL cover: reset asserted with 4 entries queued and a read in flight -> fifo_level=0, rd_valid=0, mem_en=0 immediately; no writes issued after release.
